// File: rtl/fix_sched_pkg.sv
// fix_sched_pkg: shared message-type codes, FSM state type and request
// vector constants for the FIX session message scheduler.
package fix_sched_pkg;

    localparam int NUM_REQ = 5;

    // Message type codes; each code is also the bit index in pending/grant vectors.
    localparam logic [2:0] MT_LOGON     = 3'd0;
    localparam logic [2:0] MT_HEARTBEAT = 3'd1;
    localparam logic [2:0] MT_TEST_REQ  = 3'd2;
    localparam logic [2:0] MT_LOGOUT    = 3'd3;
    localparam logic [2:0] MT_APP       = 3'd4;

    // Eligibility masks: only Logon before login, everything but Logon after.
    localparam logic [NUM_REQ-1:0] ELIG_LOGGED_OUT = 5'b00001;
    localparam logic [NUM_REQ-1:0] ELIG_LOGGED_IN  = 5'b11110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/fix_prio_arb.sv
// fix_prio_arb: combinational fixed-priority pick over the eligible pending
// vector. Order: LOGOUT > LOGON > TEST_REQ > HEARTBEAT > APP.
module fix_prio_arb
    import fix_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] grant_oh_o,
    output logic [2:0]         code_o,
    output logic               valid_o
);

    // Priority chain selecting the encoded winner and its one-hot form.
    always_comb begin
        valid_o = |req_i;
        if (req_i[MT_LOGOUT]) begin
            code_o = MT_LOGOUT;
        end else if (req_i[MT_LOGON]) begin
            code_o = MT_LOGON;
        end else if (req_i[MT_TEST_REQ]) begin
            code_o = MT_TEST_REQ;
        end else if (req_i[MT_HEARTBEAT]) begin
            code_o = MT_HEARTBEAT;
        end else begin
            code_o = MT_APP;
        end
        if (valid_o) begin
            grant_oh_o = 5'b00001 << code_o;
        end else begin
            grant_oh_o = 5'b00000;
        end
    end

endmodule

// File: rtl/fix_msg_scheduler.sv
// fix_msg_scheduler: picks the next FIX admin/application message, strobes
// the creator, waits for completion and owns MsgSeqNum and the login flag.
// Optional done-watchdog enabled by defining FIX_SCHED_WDOG_EN.
module fix_msg_scheduler
    import fix_sched_pkg::*;
#(
    parameter int SEQ_W       = 16,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             tick_i,
    input  logic [7:0]       hb_interval_i,
    input  logic             req_logon_i,
    input  logic             req_logout_i,
    input  logic             req_test_i,
    input  logic             req_app_i,
    input  logic             msg_done_i,
    output logic             start_o,
    output logic [2:0]       msg_type_o,
    output logic [4:0]       grant_o,
    output logic [SEQ_W-1:0] msg_seq_num_o,
    output logic             busy_o,
    output logic             logged_in_o,
    output logic             error_o
);

    state_e             state_q;
    logic [NUM_REQ-1:0] pend_q;
    logic [NUM_REQ-1:0] pend_d;
    logic [NUM_REQ-1:0] grant_q;
    logic [2:0]         msg_type_q;
    logic [SEQ_W-1:0]   seq_q;
    logic [7:0]         hb_cnt_q;
    logic               start_q;
    logic               busy_q;
    logic               logged_in_q;
    logic               error_q;
    logic               hold_q;     // one settle cycle in IDLE after a completion

    logic [NUM_REQ-1:0] req_s;
    logic [NUM_REQ-1:0] elig_mask_s;
    logic [NUM_REQ-1:0] arb_oh_s;
    logic [2:0]         arb_code_s;
    logic               arb_valid_s;
    logic               hb_inc_s;
    logic               hb_fire_s;
    logic               take_s;

`ifdef FIX_SCHED_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES) + 1;
    logic [WD_W-1:0] wdog_q;
`endif

    // Sequence number never takes the value 0: all-ones wraps to 1.
    function automatic logic [SEQ_W-1:0] seq_next(input logic [SEQ_W-1:0] s);
        if (s == {SEQ_W{1'b1}}) begin
            seq_next = SEQ_W'(1);
        end else begin
            seq_next = s + SEQ_W'(1);
        end
    endfunction

    fix_prio_arb u_arb (
        .req_i      (pend_q & elig_mask_s),
        .grant_oh_o (arb_oh_s),
        .code_o     (arb_code_s),
        .valid_o    (arb_valid_s)
    );

    // Heartbeat trigger, request vector, grant decision and next pending bits.
    always_comb begin
        if (logged_in_q) begin
            elig_mask_s = ELIG_LOGGED_IN;
        end else begin
            elig_mask_s = ELIG_LOGGED_OUT;
        end
        hb_inc_s  = logged_in_q && (hb_interval_i != 8'd0) && tick_i &&
                    (hb_cnt_q < hb_interval_i);
        hb_fire_s = hb_inc_s && ((hb_cnt_q + 8'd1) == hb_interval_i);
        req_s     = {req_app_i, req_logout_i, req_test_i, hb_fire_s, req_logon_i};
        take_s    = (state_q == IDLE) && !hold_q && arb_valid_s;
        // A same-type pulse in the grant cycle is absorbed by the clear term.
        if (take_s) begin
            pend_d = (pend_q | req_s) & ~arb_oh_s & elig_mask_s;
        end else begin
            pend_d = (pend_q | req_s) & elig_mask_s;
        end
    end

    // Scheduler FSM with all session state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= 5'b00000;
            grant_q     <= 5'b00000;
            msg_type_q  <= MT_LOGON;
            seq_q       <= SEQ_W'(1);
            hb_cnt_q    <= 8'd0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            logged_in_q <= 1'b0;
            error_q     <= 1'b0;
            hold_q      <= 1'b0;
`ifdef FIX_SCHED_WDOG_EN
            wdog_q      <= '0;
`endif
        end else if (!enable_i) begin
            // Session dropped: flush everything except the last message type.
            state_q     <= IDLE;
            pend_q      <= 5'b00000;
            grant_q     <= 5'b00000;
            seq_q       <= SEQ_W'(1);
            hb_cnt_q    <= 8'd0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            logged_in_q <= 1'b0;
            error_q     <= 1'b0;
            hold_q      <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            start_q <= 1'b0;
            error_q <= 1'b0;
            hold_q  <= 1'b0;
            if (start_q) begin
                hb_cnt_q <= 8'd0;
            end else if (hb_inc_s) begin
                hb_cnt_q <= hb_cnt_q + 8'd1;
            end
            case (state_q)
                IDLE: begin
                    if (take_s) begin
                        msg_type_q <= arb_code_s;
                        grant_q    <= arb_oh_s;
                        start_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
`ifdef FIX_SCHED_WDOG_EN
                    wdog_q  <= '0;
`endif
                end
                WAIT: begin
                    if (msg_done_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        grant_q <= 5'b00000;
                        hold_q  <= 1'b1;
                        if (msg_type_q == MT_LOGOUT) begin
                            logged_in_q <= 1'b0;
                            seq_q       <= SEQ_W'(1);
                        end else begin
                            seq_q <= seq_next(seq_q);
                            if (msg_type_q == MT_LOGON) begin
                                logged_in_q <= 1'b1;
                            end
                        end
`ifdef FIX_SCHED_WDOG_EN
                    end else if (wdog_q == WD_W'(WDOG_CYCLES - 1)) begin
                        // Creator hung: abandon the message without completing it.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        grant_q <= 5'b00000;
                        hold_q  <= 1'b1;
                        error_q <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    grant_q <= 5'b00000;
                end
            endcase
        end
    end

    assign start_o       = start_q;
    assign msg_type_o    = msg_type_q;
    assign grant_o       = grant_q;
    assign msg_seq_num_o = seq_q;
    assign busy_o        = busy_q;
    assign logged_in_o   = logged_in_q;
    assign error_o       = error_q;

endmodule

// File: doc/fix_msg_scheduler.md
Name: fix_msg_scheduler

Overview:
- Session-level scheduler that decides which FIX admin or application message the message-creation datapath builds next.
- Latches requests (logon, logout, test request, application) and generates heartbeats internally from a 1 s tick and the configured heartbeat interval.
- Arbitrates among pending requests by fixed priority, starts the creator with a one-cycle strobe and waits for its done indication.
- Owns the outgoing MsgSeqNum counter and the logged-in flag. Sits between the session controller and the message creator.

Parameters:
- SEQ_W, 16, width of the outgoing sequence-number counter.
- WDOG_CYCLES, 4096, done-timeout in clk cycles (used only with the watchdog feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enable_i  in  1  session connected; low flushes the scheduler
- tick_i  in  1  one-cycle 1 s strobe
- hb_interval_i  in  8  heartbeat interval in seconds; 0 disables heartbeats
- req_logon_i  in  1  pulse: request Logon
- req_logout_i  in  1  pulse: request Logout
- req_test_i  in  1  pulse: request TestRequest
- req_app_i  in  1  pulse: request application message
- msg_done_i  in  1  creator finished current message
- start_o  out  1  one-cycle start strobe to the creator
- msg_type_o  out  3  message type of the current or last grant
- grant_o  out  5  one-hot grant, bit index = msg type code
- msg_seq_num_o  out  SEQ_W  MsgSeqNum of the next or current message
- busy_o  out  1  high in ISSUE and WAIT
- logged_in_o  out  1  logon completed, logout not yet completed
- error_o  out  1  one-cycle watchdog-expiry pulse

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE.
  - start_o=0, grant_o=0, msg_type_o=0, busy_o=0, error_o=0, logged_in_o=0.
  - msg_seq_num_o=1.
  - All pending bits cleared; heartbeat counter cleared.
  - rst asserted in any state aborts the current operation.
- Pending bits:
  - Each req pulse sets its own pending bit one cycle later.
  - A pulse that coincides with the grant of the same type is absorbed; it does not re-issue.
- Heartbeat counter:
  - While logged_in and hb_interval_i≠0, the counter increments on tick_i.
  - When the count equals hb_interval_i, the hb pending bit is set and the counter holds.
  - The counter clears on every start_o.
- Eligibility:
  - Logon is eligible only when not logged in; otherwise it is dropped.
  - All other types are eligible only when logged in; otherwise they are dropped.
- Priority: LOGOUT > LOGON > TEST_REQ > HEARTBEAT > APP.
- State machine:
  - IDLE: if any eligible pending bit is set, latch the winner into msg_type_o and grant_o, clear its pending bit, and go to ISSUE.
  - ISSUE (one cycle): start_o=1, then go to WAIT. msg_done_i is ignored in this state.
  - WAIT: on msg_done_i, go to IDLE.
- Completion (state update in the cycle after msg_done_i):
  - Sequence number increments by 1. At all-ones it wraps to 1; 0 is never produced.
  - LOGON completion sets logged_in.
  - LOGOUT completion clears logged_in and sets the sequence number to 1.
- Latency:
  - Request pulse at cycle N gives start_o at N+2.
  - msg_done_i at cycle M gives the earliest next start_o at M+3.
- msg_type_o and grant_o are stable from ISSUE until the next grant. grant_o clears in IDLE.
- msg_done_i outside WAIT is ignored.
- enable_i=0 in any state, same cycle: go to IDLE, clear pending bits, logged_in and heartbeat counter, set seq=1, deassert start_o and grant_o.

Optional Feature:
- Macro: FIX_SCHED_WDOG_EN.
- Defined:
  - A counter runs in WAIT and clears on entry to WAIT.
  - If WDOG_CYCLES elapse without msg_done_i: error_o pulses one cycle and state returns to IDLE.
  - On timeout, seq does not increment, logged_in is unchanged, and the granted request is not restored.
- Undefined: WAIT waits indefinitely; error_o is tied to 0.

Decomposition:
- Package fix_sched_pkg:
  - Message type codes MT_LOGON=0, MT_HEARTBEAT=1, MT_TEST_REQ=2, MT_LOGOUT=3, MT_APP=4.
  - State enum {IDLE, ISSUE, WAIT}.
  - NUM_REQ=5.
- Sub-module fix_prio_arb: combinational fixed-priority pick on the eligible pending vector, with one-hot and encoded outputs.

Test Plan:
- Logon: reset, enable_i=1, req_logon_i pulse at cycle 10 → start_o at 12, msg_type_o=0. msg_done_i at 20 → logged_in_o=1 and msg_seq_num_o=2 from 21.
- Priority: while logged in, pulse req_app_i, req_test_i and req_logout_i in the same cycle → grants in order LOGOUT. After LOGOUT completes, TEST_REQ and APP are dropped because logged_in=0, and seq=1.
- Heartbeat: logged in, hb_interval_i=3, tick every 100 cycles with no other traffic → HEARTBEAT start_o after the 3rd tick. hb_interval_i=0 → no heartbeat.
- Seq wrap: SEQ_W=4, complete 15 messages after logon → seq goes 15→1, never 0.
- Flush: enable_i=0 during WAIT → next cycle busy_o=0, logged_in_o=0, seq=1. Later msg_done_i is ignored.
- Watchdog (FIX_SCHED_WDOG_EN, WDOG_CYCLES=8): grant with no msg_done_i → error_o pulses 8 cycles after entering WAIT, IDLE follows, seq unchanged.
